// File: rtl/cpu_tcm_responder.sv
// cpu_tcm_responder: fixed-latency TCM slave on the CPU load/store port
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   cpu_addr/wdata/byte_en, cpu_rd/cpu_wr   request fields and pulses
//   cpu_rdata, cpu_ready, cpu_err           response (ready is a 1-cycle pulse)
//   busy                                    request in flight (WAIT or RESP)
//   rd_count, wr_count, err_count           saturating response counters
module cpu_tcm_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byte_en,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        busy,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] err_count
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LAT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [3:0]    lat_cnt, lat_nx;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;
    logic          wr_q, err_q;
    logic          accept, fire, live_err, cur_err, cur_wr;
    logic [31:0]   cur_addr, cur_wdata;
    logic [3:0]    cur_be;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH_WORDS];

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return c + {15'd0, c != 16'hFFFF};
    endfunction

    assign accept   = state == IDLE && (cpu_rd || cpu_wr);
    assign live_err = cpu_addr[1:0] != 2'd0 || {1'b0, cpu_addr} < {1'b0, BASE_ADDR} ||
                      {1'b0, cpu_addr} >= LIMIT || (cpu_rd && cpu_wr);
    // With LATENCY=1 the array is accessed on the accepting edge itself, so the
    // live request fields are used in IDLE and the latched copies otherwise.
    assign fire      = (accept && LATENCY == 1) || (state == WAIT && lat_cnt == 4'd0);
    assign cur_addr  = state == IDLE ? cpu_addr : addr_q;
    assign cur_wdata = state == IDLE ? cpu_wdata : wdata_q;
    assign cur_be    = state == IDLE ? cpu_byte_en : be_q;
    assign cur_wr    = state == IDLE ? (cpu_wr && !cpu_rd) : wr_q;
    assign cur_err   = state == IDLE ? live_err : err_q;
    assign idx       = AW'((cur_addr - BASE_ADDR) >> 2);
    assign cpu_ready = state == RESP;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = fire ? RESP : (accept || state == WAIT) ? WAIT : IDLE;
        lat_nx   = accept ? LAT_INIT : lat_cnt - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else begin
            state   <= state_nx;
            lat_cnt <= lat_nx;
            if (accept) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                be_q    <= cpu_byte_en;
                wr_q    <= cpu_wr && !cpu_rd;
                err_q   <= live_err;
            end
            if (fire) begin
                cpu_err <= cur_err;
                if (cur_err) begin
                    cpu_rdata <= '0;
                    err_count <= sat_inc(err_count);
                end else if (cur_wr) begin
                    wr_count <= sat_inc(wr_count);
                end else begin
                    cpu_rdata <= mem[idx];
                    rd_count  <= sat_inc(rd_count);
                end
            end
        end
    end

    // Memory is never cleared; a reset held across an edge drops the commit.
    always_ff @(posedge clk) begin
        if (fire && !rst && cur_wr && !cur_err)
            for (int i = 0; i < 4; i++)
                if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
    end
endmodule
